// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the default-slave error FSM state type
// used by the interconnect and its arbiter.
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [1:0] {
      ERR_OKAY,
      ERR_WAIT,
      ERR_LAST
   } err_state_t;

   // NONSEQ and SEQ both carry a real transfer; IDLE and BUSY do not.
   function automatic logic is_active(input logic [1:0] htrans);
      return htrans[1];
   endfunction

endpackage

// File: rtl/ahb_rr_arbiter.sv
// Round-robin master selection: on an advance strobe, picks the first
// requester after the last grant (wrapping), otherwise holds the last grant.
module ahb_rr_arbiter #(
   parameter int NUM_MASTERS = 2,
   parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
   input  logic [NUM_MASTERS-1:0] i_req,
   input  logic [IDX_W-1:0]       i_last,
   input  logic                   i_advance,
   output logic [IDX_W-1:0]       o_grant
);

   logic w_found;

   // NOTE: every signal driven here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      o_grant = i_last;
      w_found = 1'b0;
      if (i_advance) begin
         for (int j = 0; j < NUM_MASTERS; j++) begin
            if (!w_found && i_req[j] && (j > int'(i_last))) begin
               o_grant = IDX_W'(j);
               w_found = 1'b1;
            end
         end
         // Wrap-around pass; lands back on i_last when nobody else asks.
         for (int j = 0; j < NUM_MASTERS; j++) begin
            if (!w_found && i_req[j] && (j <= int'(i_last))) begin
               o_grant = IDX_W'(j);
               w_found = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/ahb_interconnect.sv
// Multi-master AHB-Lite interconnect: round-robin arbitration, address decode,
// data-phase response routing and a two-cycle ERROR default slave.
// Optional master locking is enabled with `define AHB_LOCK_EN.
module ahb_interconnect
   import ahb_pkg::*;
#(
   parameter int NUM_MASTERS = 2,
   parameter int NUM_SLAVES  = 8,
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32
) (
   input  logic                                   hclk,
   input  logic                                   hresetn,
   input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] m_haddr_in,
   input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] m_hwdata_in,
   input  logic [NUM_MASTERS-1:0][1:0]            m_htrans_in,
   input  logic [NUM_MASTERS-1:0]                 m_hwrite_in,
   input  logic [NUM_MASTERS-1:0][2:0]            m_hsize_in,
   input  logic [NUM_MASTERS-1:0][2:0]            m_hburst_in,
   input  logic [NUM_MASTERS-1:0][3:0]            m_hprot_in,
   input  logic [NUM_MASTERS-1:0]                 m_hmastlock_in,
   output logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] m_hrdata_out,
   output logic [NUM_MASTERS-1:0]                 m_hready_out,
   output logic [NUM_MASTERS-1:0]                 m_hresp_out,
   output logic [ADDR_WIDTH-1:0]                  s_haddr_out,
   output logic [DATA_WIDTH-1:0]                  s_hwdata_out,
   output logic [1:0]                             s_htrans_out,
   output logic                                   s_hwrite_out,
   output logic [2:0]                             s_hsize_out,
   output logic [2:0]                             s_hburst_out,
   output logic [3:0]                             s_hprot_out,
   output logic                                   s_hmastlock_out,
   output logic                                   s_hready_out,
   output logic [NUM_SLAVES-1:0]                  s_hsel_out,
   input  logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0]  s_hrdata_in,
   input  logic [NUM_SLAVES-1:0]                  s_hready_in,
   input  logic [NUM_SLAVES-1:0]                  s_hresp_in,
   input  logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0]  s_base_addr_in,
   input  logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0]  s_last_addr_in
);

   localparam int MW = $clog2(NUM_MASTERS);
   localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

   typedef struct packed {
      logic          active;
      logic [MW-1:0] master;
      logic [SW-1:0] slave;
      logic          unmapped;
   } dphase_t;

   logic [MW-1:0]         grant_q;
   dphase_t               dphase_q;
   err_state_t            r_err_state;
   logic                  r_err_hready;
   logic                  r_err_hresp;

   logic [NUM_MASTERS-1:0] w_req;
   logic [MW-1:0]          w_next_grant;
   logic                   w_advance;
   logic                   w_locked;
   logic [NUM_SLAVES-1:0]  w_hsel;
   logic [SW-1:0]          w_sel_idx;
   logic                   w_hit;
   logic                   w_err_start;
   logic                   w_bus_hready;
   logic                   w_bus_hresp;
   logic [DATA_WIDTH-1:0]  w_bus_hrdata;

   // Address phase of the granted master is broadcast to every slave.
   assign s_haddr_out  = m_haddr_in[grant_q];
   assign s_htrans_out = hresetn ? m_htrans_in[grant_q] : HTRANS_IDLE;
   assign s_hwrite_out = m_hwrite_in[grant_q];
   assign s_hsize_out  = m_hsize_in[grant_q];
   assign s_hburst_out = m_hburst_in[grant_q];
   assign s_hprot_out  = m_hprot_in[grant_q];
   assign s_hwdata_out = m_hwdata_in[dphase_q.master];
   assign s_hready_out = w_bus_hready;
   assign s_hsel_out   = hresetn ? w_hsel : '0;

`ifdef AHB_LOCK_EN
   assign w_locked        = m_hmastlock_in[grant_q];
   assign s_hmastlock_out = m_hmastlock_in[grant_q];
`else
   logic w_unused_lock;
   assign w_unused_lock   = ^m_hmastlock_in;
   assign w_locked        = 1'b0;
   assign s_hmastlock_out = 1'b0;
`endif

   always_comb begin
      w_hsel    = '0;
      w_sel_idx = '0;
      w_hit     = 1'b0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (!w_hit && (s_haddr_out >= s_base_addr_in[i]) && (s_haddr_out <= s_last_addr_in[i])) begin
            w_hsel[i] = 1'b1;
            w_sel_idx = SW'(i);
            w_hit     = 1'b1;
         end
      end
   end

   assign w_err_start = is_active(s_htrans_out) && !w_hit;

   always_comb begin
      w_req = '0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         w_req[k] = is_active(m_htrans_in[k]);
      end
   end

   // BUSY only appears inside a burst, so the grant is held until a true IDLE.
   assign w_advance = w_bus_hready && (s_htrans_out == HTRANS_IDLE) && !w_locked;

   ahb_rr_arbiter #(
      .NUM_MASTERS (NUM_MASTERS),
      .IDX_W       (MW)
   ) u_arbiter (
      .i_req     (w_req),
      .i_last    (grant_q),
      .i_advance (w_advance),
      .o_grant   (w_next_grant)
   );

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of block ordering.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         grant_q  <= '0;
         dphase_q <= '0;
      end else begin
         grant_q <= w_next_grant;
         if (w_bus_hready) begin
            dphase_q.active   <= is_active(s_htrans_out);
            dphase_q.master   <= grant_q;
            dphase_q.slave    <= w_sel_idx;
            dphase_q.unmapped <= !w_hit;
         end
      end
   end

   // Default slave: loaded alongside dphase_q, so its outputs line up with
   // the first data-phase cycle of an unmapped transfer.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         r_err_state  <= ERR_OKAY;
         r_err_hready <= 1'b1;
         r_err_hresp  <= HRESP_OKAY;
      end else begin
         case (r_err_state)
            ERR_WAIT: begin
               r_err_state  <= ERR_LAST;
               r_err_hready <= 1'b1;
               r_err_hresp  <= HRESP_ERROR;
            end
            default: begin
               if (w_bus_hready) begin
                  if (w_err_start) begin
                     r_err_state  <= ERR_WAIT;
                     r_err_hready <= 1'b0;
                     r_err_hresp  <= HRESP_ERROR;
                  end else begin
                     r_err_state  <= ERR_OKAY;
                     r_err_hready <= 1'b1;
                     r_err_hresp  <= HRESP_OKAY;
                  end
               end
            end
         endcase
      end
   end

   always_comb begin
      w_bus_hready = 1'b1;
      w_bus_hresp  = HRESP_OKAY;
      w_bus_hrdata = '0;
      if (dphase_q.active) begin
         if (dphase_q.unmapped) begin
            w_bus_hready = r_err_hready;
            w_bus_hresp  = r_err_hresp;
         end else begin
            w_bus_hready = s_hready_in[dphase_q.slave];
            w_bus_hresp  = s_hresp_in[dphase_q.slave];
            w_bus_hrdata = s_hrdata_in[dphase_q.slave];
         end
      end
   end

   // Non-granted masters see HREADY low, which keeps their address phase held.
   always_comb begin
      m_hready_out = '0;
      m_hresp_out  = '0;
      m_hrdata_out = '0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         if ((MW'(k) == grant_q) || (MW'(k) == dphase_q.master)) begin
            m_hready_out[k] = w_bus_hready;
         end
         if (MW'(k) == dphase_q.master) begin
            m_hresp_out[k]  = w_bus_hresp;
            m_hrdata_out[k] = w_bus_hrdata;
         end
      end
   end

endmodule

// File: tb/tb_ahb_interconnect.sv
// Self-checking bench for ahb_interconnect: directed scenarios plus randomized
// decode and arbitration rounds checked against a behavioural model.
module tb_ahb_interconnect;
   import ahb_pkg::*;

   localparam int NM = 2;
   localparam int NS = 8;
   localparam int AW = 32;
   localparam int DW = 32;

   logic hclk = 1'b0;
   logic hresetn;
   always #5 hclk = ~hclk;

   logic [NM-1:0][AW-1:0] m_haddr;
   logic [NM-1:0][DW-1:0] m_hwdata;
   logic [NM-1:0][1:0]    m_htrans;
   logic [NM-1:0]         m_hwrite;
   logic [NM-1:0][2:0]    m_hsize;
   logic [NM-1:0][2:0]    m_hburst;
   logic [NM-1:0][3:0]    m_hprot;
   logic [NM-1:0]         m_hmastlock;
   logic [NM-1:0][DW-1:0] m_hrdata;
   logic [NM-1:0]         m_hready;
   logic [NM-1:0]         m_hresp;
   logic [AW-1:0]         s_haddr;
   logic [DW-1:0]         s_hwdata;
   logic [1:0]            s_htrans;
   logic                  s_hwrite;
   logic [2:0]            s_hsize;
   logic [2:0]            s_hburst;
   logic [3:0]            s_hprot;
   logic                  s_hmastlock;
   logic                  s_hready;
   logic [NS-1:0]         s_hsel;
   logic [NS-1:0][DW-1:0] s_hrdata;
   logic [NS-1:0]         s_hready_in;
   logic [NS-1:0]         s_hresp_in;
   logic [NS-1:0][AW-1:0] s_base;
   logic [NS-1:0][AW-1:0] s_last;
   logic [NS-1:0]         slave_wait;

   int n_cmp = 0;
   int n_bad = 0;
   int g_model = 0;

   ahb_interconnect #(
      .NUM_MASTERS (NM), .NUM_SLAVES (NS), .ADDR_WIDTH (AW), .DATA_WIDTH (DW)
   ) dut (
      .hclk (hclk), .hresetn (hresetn),
      .m_haddr_in (m_haddr), .m_hwdata_in (m_hwdata), .m_htrans_in (m_htrans),
      .m_hwrite_in (m_hwrite), .m_hsize_in (m_hsize), .m_hburst_in (m_hburst),
      .m_hprot_in (m_hprot), .m_hmastlock_in (m_hmastlock),
      .m_hrdata_out (m_hrdata), .m_hready_out (m_hready), .m_hresp_out (m_hresp),
      .s_haddr_out (s_haddr), .s_hwdata_out (s_hwdata), .s_htrans_out (s_htrans),
      .s_hwrite_out (s_hwrite), .s_hsize_out (s_hsize), .s_hburst_out (s_hburst),
      .s_hprot_out (s_hprot), .s_hmastlock_out (s_hmastlock), .s_hready_out (s_hready),
      .s_hsel_out (s_hsel), .s_hrdata_in (s_hrdata), .s_hready_in (s_hready_in),
      .s_hresp_in (s_hresp_in), .s_base_addr_in (s_base), .s_last_addr_in (s_last)
   );

   function automatic logic [DW-1:0] slave_data(input int i);
      return 32'hD000_0000 + 32'(i) * 32'h100;
   endfunction

   // Map: slave i owns [i*0x1000_0000, +0x0FFF_FFFF]; slave 6 also spans
   // slave 7's window, so the overlap must resolve to 6; >= 0x8000_0000 unmapped.
   function automatic logic [NS-1:0] exp_hsel(input logic [AW-1:0] a);
      if (a < 32'h6000_0000) return 8'(1) << a[31:28];
      else if (a < 32'h8000_0000) return 8'h40;
      else return 8'h00;
   endfunction

   always_comb begin
      for (int i = 0; i < NS; i++) begin
         s_hrdata[i]    = slave_data(i);
         s_base[i]      = AW'(i) << 28;
         s_last[i]      = (AW'(i) << 28) + 32'h0FFF_FFFF;
         s_hready_in[i] = !slave_wait[i];
      end
      s_last[6]  = 32'h7FFF_FFFF;
      s_hresp_in = '0;
   end

   task automatic step();
      @(posedge hclk);
      #1;
   endtask

   task automatic mid();
      @(negedge hclk);
   endtask

   task automatic idle_all();
      for (int k = 0; k < NM; k++) begin
         m_htrans[k] = HTRANS_IDLE; m_haddr[k] = '0; m_hwrite[k] = 1'b0;
         m_hsize[k] = 3'b010; m_hburst[k] = 3'b000; m_hprot[k] = 4'b0011;
         m_hmastlock[k] = 1'b0; m_hwdata[k] = 32'h1111_1111 * (k + 1);
      end
   endtask

   // One single read by master k; moves the grant to k.
   task automatic single_xfer(input int k, input logic [AW-1:0] addr);
      bit done = 0;
      m_htrans[k] = HTRANS_NONSEQ; m_haddr[k] = addr; m_hwrite[k] = 1'b0;
      for (int c = 0; c < 16 && !done; c++) begin
         mid();
         if (s_hready && s_htrans == HTRANS_NONSEQ && s_haddr == addr) done = 1;
         step();
      end
      n_cmp++;
      if (!done) begin n_bad++; $display("FAIL xfer_timeout: master %0d got no grant, want grant within 16 cycles", k); end
      m_htrans[k] = HTRANS_IDLE;
      step();
      g_model = k;
   endtask

   task automatic test_reset();
      hresetn = 1'b0; idle_all(); slave_wait = '0;
      m_htrans[0] = HTRANS_NONSEQ; m_haddr[0] = 32'h1000_0000;
      m_htrans[1] = HTRANS_NONSEQ; m_haddr[1] = 32'h2000_0000;
      step(); step(); mid();
      n_cmp++; if (s_hsel !== '0) begin n_bad++; $display("FAIL rst_hsel: got %h want 00", s_hsel); end
      n_cmp++; if (s_htrans !== HTRANS_IDLE) begin n_bad++; $display("FAIL rst_htrans: got %b want 00", s_htrans); end
      n_cmp++; if (s_hready !== 1'b1) begin n_bad++; $display("FAIL rst_hready: got %b want 1", s_hready); end
      n_cmp++; if (m_hready !== 2'b01) begin n_bad++; $display("FAIL rst_m_hready: got %b want 01", m_hready); end
      n_cmp++; if (m_hresp !== 2'b00) begin n_bad++; $display("FAIL rst_m_hresp: got %b want 00", m_hresp); end
      n_cmp++; if (m_hrdata !== '0) begin n_bad++; $display("FAIL rst_m_hrdata: got %h want 0", m_hrdata); end
      n_cmp++; if (dut.grant_q !== '0) begin n_bad++; $display("FAIL rst_grant: got %0d want 0", dut.grant_q); end
      step(); idle_all(); hresetn = 1'b1; step();
      g_model = 0;
   endtask

   task automatic test_single_write();
      m_htrans[0] = HTRANS_NONSEQ; m_haddr[0] = 32'h1000_0000; m_hwrite[0] = 1'b1;
      m_hburst[0] = 3'b000; m_hsize[0] = 3'b010; m_hprot[0] = 4'b0011; m_hwdata[0] = 32'h0BAD_F00D;
      mid();
      n_cmp++; if (s_hsel !== 8'b0000_0010) begin n_bad++; $display("FAIL wr_hsel: got %b want 00000010", s_hsel); end
      n_cmp++; if (s_haddr !== 32'h1000_0000 || s_hwrite !== 1'b1) begin n_bad++; $display("FAIL wr_addr: got %h/%b want 10000000/1", s_haddr, s_hwrite); end
      n_cmp++; if ({s_hsize, s_hburst, s_hprot} !== {3'b010, 3'b000, 4'b0011}) begin n_bad++; $display("FAIL wr_ctrl: got %b want 0100000011", {s_hsize, s_hburst, s_hprot}); end
      n_cmp++; if (m_hready[0] !== 1'b1) begin n_bad++; $display("FAIL wr_m0_ready: got %b want 1", m_hready[0]); end
      step();
      m_htrans[0] = HTRANS_IDLE; m_hwrite[0] = 1'b0; m_hwdata[0] = 32'hCAFE_BABE;
      mid();
      n_cmp++; if (s_hwdata !== 32'hCAFE_BABE) begin n_bad++; $display("FAIL wr_hwdata: got %h want cafebabe", s_hwdata); end
      n_cmp++; if (s_hready !== 1'b1 || m_hresp[0] !== 1'b0) begin n_bad++; $display("FAIL wr_zero_wait: got ready %b resp %b want 1/0", s_hready, m_hresp[0]); end
      step();
   endtask

   task automatic test_read_wait();
      m_htrans[0] = HTRANS_NONSEQ; m_haddr[0] = 32'h2000_0040;
      step();
      m_htrans[0] = HTRANS_IDLE; slave_wait[2] = 1'b1;
      for (int c = 0; c < 2; c++) begin
         mid();
         n_cmp++; if (s_hready !== 1'b0 || m_hready[0] !== 1'b0) begin n_bad++; $display("FAIL rd_wait%0d: got %b/%b want 0/0", c, s_hready, m_hready[0]); end
         step();
      end
      slave_wait[2] = 1'b0;
      mid();
      n_cmp++; if (s_hready !== 1'b1) begin n_bad++; $display("FAIL rd_done: got %b want 1", s_hready); end
      n_cmp++; if (m_hrdata[0] !== slave_data(2)) begin n_bad++; $display("FAIL rd_data: got %h want %h", m_hrdata[0], slave_data(2)); end
      n_cmp++; if (m_hrdata[1] !== '0 || m_hresp[1] !== 1'b0) begin n_bad++; $display("FAIL rd_other: got %h/%b want 0/0", m_hrdata[1], m_hresp[1]); end
      step();
   endtask

   task automatic test_decode_random();
      logic [AW-1:0] a;
      logic [AW-1:0] edges [6];
      edges[0] = 32'h0000_0000; edges[1] = 32'h5FFF_FFFF; edges[2] = 32'h6000_0000;
      edges[3] = 32'h7000_0010; edges[4] = 32'h7FFF_FFFF; edges[5] = 32'h8000_0000;
      for (int i = 0; i < 16; i++) begin
         if (i < 6) a = edges[i];
         else if (i % 2 == 0) a = $urandom() & 32'h7FFF_FFFF;
         else a = $urandom();
         m_haddr[0] = a; m_haddr[1] = a;
         mid();
         n_cmp++; if (s_hsel !== exp_hsel(a)) begin n_bad++; $display("FAIL decode %h: got %b want %b", a, s_hsel, exp_hsel(a)); end
         step();
      end
      idle_all();
   endtask

   task automatic test_contention();
      m_htrans[0] = HTRANS_NONSEQ; m_haddr[0] = 32'h1000_0100;
      m_htrans[1] = HTRANS_NONSEQ; m_haddr[1] = 32'h3000_0200;
      mid();
      n_cmp++; if (s_haddr !== 32'h1000_0100 || m_hready[1] !== 1'b0) begin n_bad++; $display("FAIL cont_a: got %h/%b want 10000100/0", s_haddr, m_hready[1]); end
      step();
      m_htrans[0] = HTRANS_IDLE;
      mid();
      n_cmp++; if (m_hready[1] !== 1'b0) begin n_bad++; $display("FAIL cont_b: got m1 ready %b want 0", m_hready[1]); end
      step();
      mid();
      n_cmp++; if (s_haddr !== 32'h3000_0200 || s_hsel !== 8'h08 || m_hready[1] !== 1'b1) begin n_bad++; $display("FAIL cont_c: got %h/%b/%b want 30000200/00001000/1", s_haddr, s_hsel, m_hready[1]); end
      step();
      m_htrans[1] = HTRANS_IDLE;
      step();
      g_model = 1;
   endtask

   task automatic test_burst();
      logic [AW-1:0] got [$];
      int            got_c [$];
      int            beat = 0;
      bit            m1_pend = 1;
      single_xfer(0, 32'h1000_0300);
      for (int c = 0; c < 20; c++) begin
         m_htrans[0] = (beat == 0) ? HTRANS_NONSEQ : (beat < 4) ? HTRANS_SEQ : HTRANS_IDLE;
         m_haddr[0]  = 32'h1000_0000 + AW'(beat * 4); m_hburst[0] = 3'b011;
         m_htrans[1] = m1_pend ? HTRANS_NONSEQ : HTRANS_IDLE; m_haddr[1] = 32'h3000_0000;
         mid();
         if (s_hready && s_htrans[1]) begin
            got.push_back(s_haddr); got_c.push_back(c);
            if (s_haddr == 32'h3000_0000) m1_pend = 0; else beat++;
         end
         step();
      end
      idle_all(); step();
      g_model = 1;
      n_cmp++;
      if (got.size() != 5) begin
         n_bad++; $display("FAIL burst_count: got %0d accepted transfers want 5", got.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_cmp++; if (got[i] !== 32'h1000_0000 + AW'(i * 4)) begin n_bad++; $display("FAIL burst_beat%0d: got %h want %h", i, got[i], 32'h1000_0000 + AW'(i * 4)); end
         end
         n_cmp++; if (got[4] !== 32'h3000_0000) begin n_bad++; $display("FAIL burst_m1_last: got %h want 30000000", got[4]); end
         n_cmp++; if (got_c[3] - got_c[0] != 3) begin n_bad++; $display("FAIL burst_b2b: got span %0d want 3", got_c[3] - got_c[0]); end
         n_cmp++; if (got_c[4] - got_c[3] != 2) begin n_bad++; $display("FAIL burst_handover: got gap %0d want 2", got_c[4] - got_c[3]); end
      end
   endtask

   task automatic test_unmapped();
      single_xfer(0, 32'h1000_0400);
      m_htrans[0] = HTRANS_NONSEQ; m_haddr[0] = 32'hFFFF_0000;
      mid();
      n_cmp++; if (s_hsel !== '0 || s_hready !== 1'b1) begin n_bad++; $display("FAIL unm_addr: got %b/%b want 0/1", s_hsel, s_hready); end
      step();
      m_htrans[0] = HTRANS_IDLE;
      mid();
      n_cmp++; if ({s_hready, m_hready[0], m_hresp[0], m_hresp[1]} !== 4'b0010) begin n_bad++; $display("FAIL unm_err1: got %b want 0010", {s_hready, m_hready[0], m_hresp[0], m_hresp[1]}); end
      step();
      mid();
      n_cmp++; if ({s_hready, m_hresp[0]} !== 2'b11) begin n_bad++; $display("FAIL unm_err2: got %b want 11", {s_hready, m_hresp[0]}); end
      step();
      mid();
      n_cmp++; if ({s_hready, m_hresp[0]} !== 2'b10) begin n_bad++; $display("FAIL unm_idle_ok: got %b want 10", {s_hready, m_hresp[0]}); end
      step();
      idle_all();
   endtask

   task automatic test_rr_random();
      for (int r = 0; r < 10; r++) begin
         logic [NM-1:0] req;
         logic [NM-1:0] pend;
         logic [AW-1:0] a [NM];
         int exp_q [$];
         int got_q [$];
         req = NM'($urandom_range(1, 3));
         if (req[g_model]) exp_q.push_back(g_model);
         for (int j = 1; j < NM; j++) if (req[(g_model + j) % NM]) exp_q.push_back((g_model + j) % NM);
         for (int k = 0; k < NM; k++) a[k] = 32'h2000_0000 + AW'(k) * 32'h1000_0000 + AW'(r * 16);
         pend = req;
         for (int c = 0; c < 12 && pend != '0; c++) begin
            for (int k = 0; k < NM; k++) begin
               m_htrans[k] = pend[k] ? HTRANS_NONSEQ : HTRANS_IDLE; m_haddr[k] = a[k];
            end
            mid();
            if (s_hready && s_htrans == HTRANS_NONSEQ) begin
               for (int k = 0; k < NM; k++) begin
                  if (pend[k] && s_haddr == a[k]) begin
                     got_q.push_back(k); pend[k] = 1'b0;
                     n_cmp++; if (m_hready[k] !== 1'b1) begin n_bad++; $display("FAIL rr_ready r%0d m%0d: got %b want 1", r, k, m_hready[k]); end
                  end
               end
            end
            step();
         end
         idle_all(); step();
         n_cmp++;
         if (got_q != exp_q) begin
            n_bad++; $display("FAIL rr_order r%0d req %b: got %p want %p", r, req, got_q, exp_q);
         end
         g_model = exp_q[exp_q.size() - 1];
      end
   endtask

   task automatic test_lock();
      single_xfer(0, 32'h1000_0500);
      m_hmastlock[0] = 1'b1;
      m_htrans[1] = HTRANS_NONSEQ; m_haddr[1] = 32'h3000_0500;
`ifdef AHB_LOCK_EN
      for (int c = 0; c < 4; c++) begin
         mid();
         n_cmp++; if (s_hmastlock !== 1'b1 || m_hready[1] !== 1'b0 || s_haddr === 32'h3000_0500) begin n_bad++; $display("FAIL lock_hold%0d: got lock %b m1 ready %b addr %h want 1/0/not m1", c, s_hmastlock, m_hready[1], s_haddr); end
         step();
      end
      m_hmastlock[0] = 1'b0;
      step();
`else
      step();
`endif
      mid();
      n_cmp++; if (s_haddr !== 32'h3000_0500 || m_hready[1] !== 1'b1 || s_hmastlock !== 1'b0) begin n_bad++; $display("FAIL lock_release: got %h/%b/%b want 30000500/1/0", s_haddr, m_hready[1], s_hmastlock); end
      step();
      idle_all(); step();
      g_model = 1;
   endtask

   task automatic test_reset_midxfer();
      single_xfer(1, 32'h3000_0600);
      m_htrans[1] = HTRANS_NONSEQ; m_haddr[1] = 32'h2000_0080; slave_wait[2] = 1'b1;
      step();
      m_htrans[1] = HTRANS_IDLE;
      mid();
      n_cmp++; if (s_hready !== 1'b0) begin n_bad++; $display("FAIL rmid_stall: got %b want 0", s_hready); end
      hresetn = 1'b0;
      #1;
      n_cmp++; if (s_hready !== 1'b1 || m_hresp !== 2'b00) begin n_bad++; $display("FAIL rmid_abort: got %b/%b want 1/00", s_hready, m_hresp); end
      step(); step();
      hresetn = 1'b1;
      mid();
      n_cmp++; if (dut.grant_q !== '0) begin n_bad++; $display("FAIL rmid_grant: got %0d want 0", dut.grant_q); end
      n_cmp++; if (dut.dphase_q.active !== 1'b0) begin n_bad++; $display("FAIL rmid_dphase: got %b want 0", dut.dphase_q.active); end
      n_cmp++; if (s_hready !== 1'b1 || m_hready !== 2'b01) begin n_bad++; $display("FAIL rmid_ready: got %b/%b want 1/01", s_hready, m_hready); end
      slave_wait = '0;
      step();
      g_model = 0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_write();
      test_read_wait();
      test_decode_random();
      test_contention();
      test_burst();
      test_unmapped();
      test_rr_random();
      test_lock();
      test_reset_midxfer();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
